controle_chamadas: RTL
======================

Name: controle_chamadas

Overview:
Elevator call-request controller that generates the up/down movement command and the current floor consumed by floor control and by display_andar.
- Latches floor-call buttons and schedules them with a SCAN policy: keep the current direction while requests remain ahead, otherwise reverse.
- Sequences travel and door-open intervals using a slow tick derived from divisor_frequencia.
- Sits between the board push-buttons and the floor/display logic.

Parameters:
N_ANDARES, 4, number of floors (>=2); floor index width AW = $clog2(N_ANDARES)
TEMPO_ANDAR, 2, ticks needed to travel one floor (>=1)
TEMPO_PORTA, 3, ticks the door stays open at a served floor (>=1)

Ports:
clock_in  input  1  board clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
tick  input  1  single-cycle enable pulse, timing base for travel/door counters
botoes  input  N_ANDARES  raw call buttons, active-low, asynchronous to clock_in; bit i = floor i
andar_atual  output  AW  current floor index
controleSubDes  output  1  direction: 1 = up, 0 = down
movendo  output  1  high in SUBINDO/DESCENDO
porta_aberta  output  1  high in PORTA
pedidos  output  N_ANDARES  pending-request bitmap (LEDs)

Behaviour:
- Reset, applied on the clock edge where reset=1: andar_atual=0, controleSubDes=1, movendo=0, porta_aberta=0, pedidos=0, state=PARADO, counter=0, sync flops=all-ones (released).
- A reset asserted mid-travel or mid-door aborts immediately and drops all pending requests.
- Inputs: each botoes bit passes through a 2-flop synchronizer, then a falling-edge detector (press).
  - A press sets pedidos[i] 3 cycles after the pin falls.
  - A held button sets the request only once.
- FSM states: PARADO, SUBINDO, DESCENDO, PORTA. All outputs are registered.
- PARADO: evaluated every clock, no tick needed. Priority order:
  1. pedidos[andar_atual]=1: clear it, go to PORTA.
  2. Request above and (controleSubDes=1 or no request below): controleSubDes=1, go to SUBINDO.
  3. Request below: controleSubDes=0, go to DESCENDO.
  4. Otherwise stay; controleSubDes holds its value.
- SUBINDO/DESCENDO:
  - Counter clears on entry and increments on tick.
  - On the TEMPO_ANDAR-th tick, andar_atual moves ±1 and the FSM returns to PARADO.
  - andar_atual never wraps: it saturates at 0 and N_ANDARES-1, since the scheduler only moves toward existing requests.
- PORTA:
  - Counter clears on entry; on the TEMPO_PORTA-th tick, return to PARADO.
  - A press at the current floor while in PORTA does not set pedidos and restarts the door counter (door re-open).
- Request latching in the travel states:
  - A press at the current floor during SUBINDO/DESCENDO sets pedidos.
  - That request is served on the next visit.
- Simultaneous press at floor j and clear of floor j in the same cycle: the clear wins only when j=andar_atual in the PARADO→PORTA transition; otherwise set wins.
- tick and state-entry in the same cycle: that tick is not counted.
- Latency from press (request newly set, pin falling) to movendo rising: 3 sync/edge cycles + 1 PARADO evaluation cycle = 4 clocks.

Optional Feature:
EMERGENCIA_EN
- Defined: adds input port emergencia (1 bit, active-high, already synchronous).
  - While high: state forced to EMERGENCIA, movendo=0, porta_aberta=0, pedidos cleared, new presses ignored, andar_atual held.
  - Travel in progress is abandoned without changing floor.
  - On release: go to PARADO with counter=0.
- Not defined: the port and state do not exist; behaviour is exactly as above.

Test Plan:
1. Reset, no buttons, 20 ticks -> andar_atual=0, pedidos=0, movendo=0, porta_aberta=0 throughout.
2. From floor 0, press botoes[2] -> pedidos=4'b0100 after 3 clocks; movendo=1 one clock later with controleSubDes=1; andar_atual=1 after 2 ticks and =2 after 4 ticks; then porta_aberta=1, pedidos=0; door closes after 3 ticks.
3. Elevator moving up from floor 1 toward 3, press floor 0 then floor 2 -> stops at 2 (door), then 3, then reverses (controleSubDes=0) to 0; pedidos empties in order 2, 3, 0.
4. At floor 1 with door open 2 ticks, press botoes[1] -> pedidos[1] stays 0 and door stays open 3 more ticks.
5. Hold botoes[3] low for 50 clocks while elevator is at floor 3 in PARADO -> single PORTA cycle (3 ticks), no second open.
6. EMERGENCIA_EN: pulse emergencia high during travel 0→1 after 1 tick -> movendo=0, pedidos=0, andar_atual=0; after release, state PARADO, idle.

Source files
------------

// File: rtl/controle_chamadas.sv
// Elevator call controller: synchronizes active-low call buttons, latches requests and
// schedules them SCAN-style. Optional build macro EMERGENCIA_EN adds the emergencia input.
module controle_chamadas #(
  parameter int N_ANDARES   = 4,
  parameter int TEMPO_ANDAR = 2,
  parameter int TEMPO_PORTA = 3,
  localparam int AW = (N_ANDARES > 1) ? $clog2(N_ANDARES) : 1
) (
  input  logic                 clock_in,
  input  logic                 reset,
  input  logic                 tick,
`ifdef EMERGENCIA_EN
  input  logic                 emergencia,
`endif
  input  logic [N_ANDARES-1:0] botoes,
  output logic [AW-1:0]        andar_atual,
  output logic                 controleSubDes,
  output logic                 movendo,
  output logic                 porta_aberta,
  output logic [N_ANDARES-1:0] pedidos
);

  localparam int              TMAX      = (TEMPO_ANDAR > TEMPO_PORTA) ? TEMPO_ANDAR : TEMPO_PORTA;
  localparam int              CW        = $clog2(TMAX) + 1;
  localparam logic [CW-1:0]   FIM_ANDAR = CW'(TEMPO_ANDAR - 1);
  localparam logic [CW-1:0]   FIM_PORTA = CW'(TEMPO_PORTA - 1);
  localparam logic [AW-1:0]   TOPO      = AW'(N_ANDARES - 1);

  typedef enum logic [2:0] {
    PARADO,
    SUBINDO,
    DESCENDO,
`ifdef EMERGENCIA_EN
    EMERGENCIA,
`endif
    PORTA
  } estado_t;

  estado_t                estado_q, estado_d;
  logic [N_ANDARES-1:0]   sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [N_ANDARES-1:0]   pedidos_q, pedidos_d;
  logic [AW-1:0]          andar_q, andar_d;
  logic                   dir_q, dir_d;
  logic                   movendo_q, movendo_d;
  logic                   porta_q, porta_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic [N_ANDARES-1:0]   press, set_req, clr_req;
  logic                   acima, abaixo;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    sync1_d   = botoes;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    press     = prev_q & ~sync2_q;
    estado_d  = estado_q;
    andar_d   = andar_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    set_req   = press;
    clr_req   = '0;

    acima  = 1'b0;
    abaixo = 1'b0;
    for (int i = 0; i < N_ANDARES; i++) begin
      if (i > int'(andar_q)) acima  = acima  | pedidos_q[i];
      if (i < int'(andar_q)) abaixo = abaixo | pedidos_q[i];
    end

    case (estado_q)
      PARADO: begin
        cnt_d = '0;
        if (pedidos_q[andar_q]) begin
          clr_req[andar_q] = 1'b1;
          estado_d         = PORTA;
        end else if (acima && (dir_q || !abaixo)) begin
          dir_d    = 1'b1;
          estado_d = SUBINDO;
        end else if (abaixo) begin
          dir_d    = 1'b0;
          estado_d = DESCENDO;
        end
      end
      SUBINDO, DESCENDO: begin
        if (tick) begin
          if (cnt_q >= FIM_ANDAR) begin
            cnt_d    = '0;
            estado_d = PARADO;
            if (estado_q == SUBINDO) begin
              if (andar_q != TOPO) andar_d = andar_q + AW'(1);
            end else begin
              if (andar_q != '0) andar_d = andar_q - AW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      PORTA: begin
        // A call at the open floor re-opens the door instead of queueing a request.
        set_req[andar_q] = 1'b0;
        if (press[andar_q]) begin
          cnt_d = '0;
        end else if (tick) begin
          if (cnt_q >= FIM_PORTA) begin
            cnt_d    = '0;
            estado_d = PARADO;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
`ifdef EMERGENCIA_EN
      EMERGENCIA: begin
        cnt_d    = '0;
        estado_d = PARADO;
      end
`endif
      default: begin
        cnt_d    = '0;
        estado_d = PARADO;
      end
    endcase

    pedidos_d = (pedidos_q | set_req) & ~clr_req;

`ifdef EMERGENCIA_EN
    if (emergencia) begin
      estado_d  = EMERGENCIA;
      cnt_d     = '0;
      andar_d   = andar_q;
      dir_d     = dir_q;
      pedidos_d = '0;
    end
`endif

    movendo_d = (estado_d == SUBINDO) || (estado_d == DESCENDO);
    porta_d   = (estado_d == PORTA);
  end

  always_ff @(posedge clock_in) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      estado_q  <= PARADO;
      sync1_q   <= '1;
      sync2_q   <= '1;
      prev_q    <= '1;
      pedidos_q <= '0;
      andar_q   <= '0;
      dir_q     <= 1'b1;
      movendo_q <= 1'b0;
      porta_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      estado_q  <= estado_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      pedidos_q <= pedidos_d;
      andar_q   <= andar_d;
      dir_q     <= dir_d;
      movendo_q <= movendo_d;
      porta_q   <= porta_d;
      cnt_q     <= cnt_d;
    end
  end

  assign andar_atual    = andar_q;
  assign controleSubDes = dir_q;
  assign movendo        = movendo_q;
  assign porta_aberta   = porta_q;
  assign pedidos        = pedidos_q;

endmodule
